// File: rtl/clk_div_pkg.sv
// Shared types and default parameters for the programmable clock divider.
// Imported by the counter and the controller.
package clk_div_pkg;

    localparam int WIDTH_DEFAULT       = 4;
    localparam int BURST_W_DEFAULT     = 8;
    localparam int DEFAULT_MOD_DEFAULT = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-M up counter with loadable modulus and sync clear.
// tc is combinational and only asserted while counting is enabled.
module mod_counter
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int DEFAULT_MOD = DEFAULT_MOD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_mod,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] mod_q, mod_d;

    assign q  = q_q;
    assign tc = en && (q_q == mod_q - WIDTH'(1));

    // Next count and modulus; a load lands together with the wrap.
    always_comb begin
        q_d   = q_q;
        mod_d = mod_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = tc ? '0 : q_q + WIDTH'(1);
        end
        if (load) begin
            mod_d = load_mod;
        end
    end

    // Count and modulus registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q   <= '0;
            mod_q <= WIDTH'(DEFAULT_MOD);
        end else begin
            q_q   <= q_d;
            mod_q <= mod_d;
        end
    end

endmodule

// File: rtl/clk_div_controller.sv
// Programmable clock divider: IDLE/RUN control, burst counting and
// a one-entry shadow for configuration changes made while running.
module clk_div_controller
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int DEFAULT_MOD = DEFAULT_MOD_DEFAULT,
    parameter int BURST_W     = BURST_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_mod,
    input  logic [BURST_W-1:0] cfg_bursts,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic [WIDTH-1:0]   Q,
    output logic               tc,
    output logic               out,
    output logic               done,
    output logic               cfg_err
);

    state_e             state_q, state_d;
    logic               out_q, out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BURST_W-1:0] bursts_q, bursts_d;
    logic [BURST_W-1:0] tcnt_q, tcnt_d;
    logic               shv_q, shv_d;
    logic [WIDTH-1:0]   shmod_q, shmod_d;
    logic [BURST_W-1:0] shbur_q, shbur_d;

    logic               cnt_en;
    logic               cnt_clr;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_mod;
    logic               fire;
    logic               legal;
    logic [BURST_W-1:0] tcnt_inc;
    logic               burst_end;

    assign cfg_ready = (state_q == IDLE) || !shv_q;
    assign fire      = cfg_valid && cfg_ready;
    assign legal     = cfg_mod >= WIDTH'(2);
    assign tcnt_inc  = tcnt_q + BURST_W'(1);
    assign burst_end = tc && (bursts_q != '0) && (tcnt_inc == bursts_q);
    assign cnt_en    = (state_q == RUN);

    assign busy    = (state_q == RUN);
    assign out     = out_q;
    assign done    = done_q;
    assign cfg_err = err_q;

    mod_counter #(
        .WIDTH       (WIDTH),
        .DEFAULT_MOD (DEFAULT_MOD)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_mod (cnt_mod),
        .q        (Q),
        .tc       (tc)
    );

    // Next state, configuration routing and output pulses.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        done_d   = 1'b0;
        err_d    = fire && !legal;
        bursts_d = bursts_q;
        tcnt_d   = tcnt_q;
        shv_d    = shv_q;
        shmod_d  = shmod_q;
        shbur_d  = shbur_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_mod  = shmod_q;
        unique case (state_q)
            IDLE: begin
                if (fire && legal) begin
                    cnt_load = 1'b1;
                    cnt_mod  = cfg_mod;
                    bursts_d = cfg_bursts;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    tcnt_d  = '0;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                if (tc) begin
                    out_d = !out_q;
                end
                if (stop || burst_end) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    done_d  = !stop;
                    if (fire && legal) begin
                        cnt_load = 1'b1;
                        cnt_mod  = cfg_mod;
                        bursts_d = cfg_bursts;
                    end else if (shv_q) begin
                        cnt_load = 1'b1;
                        bursts_d = shbur_q;
                        shv_d    = 1'b0;
                    end
                end else begin
                    if (tc) begin
                        if (shv_q) begin
                            cnt_load = 1'b1;
                            bursts_d = shbur_q;
                            shv_d    = 1'b0;
                            tcnt_d   = '0;
                        end else begin
                            tcnt_d = tcnt_inc;
                        end
                    end
                    if (fire && legal) begin
                        shv_d   = 1'b1;
                        shmod_d = cfg_mod;
                        shbur_d = cfg_bursts;
                    end
                end
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            out_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bursts_q <= '0;
            tcnt_q   <= '0;
            shv_q    <= 1'b0;
            shmod_q  <= '0;
            shbur_q  <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            done_q   <= done_d;
            err_q    <= err_d;
            bursts_q <= bursts_d;
            tcnt_q   <= tcnt_d;
            shv_q    <= shv_d;
            shmod_q  <= shmod_d;
            shbur_q  <= shbur_d;
        end
    end

endmodule

// File: tb/tb_clk_div_controller.sv
// Directed scoreboard bench for clk_div_controller.
// Expected per-cycle outputs are queued, then popped and checked.
module tb_clk_div_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_mod;
    logic [7:0] cfg_bursts;
    logic       start;
    logic       stop;
    logic       busy;
    logic [3:0] Q;
    logic       tc;
    logic       out;
    logic       done;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;
    bit exp_out  = 1'b0;

    typedef struct {
        string tag;
        int    q;
        bit    tc;
        bit    out;
        bit    busy;
        bit    done;
        bit    err;
        bit    rdy;
    } exp_t;

    exp_t sb[$];

    clk_div_controller #(
        .WIDTH       (4),
        .DEFAULT_MOD (6),
        .BURST_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mod    (cfg_mod),
        .cfg_bursts (cfg_bursts),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .Q          (Q),
        .tc         (tc),
        .out        (out),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, got, want);
        end
    endtask

    task automatic push(input string tag, input int q, input bit t,
                        input bit o, input bit b, input bit d,
                        input bit e, input bit r);
        exp_t x;
        x.tag = tag; x.q = q; x.tc = t; x.out = o;
        x.busy = b; x.done = d; x.err = e; x.rdy = r;
        sb.push_back(x);
    endtask

    task automatic chk();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        x = sb.pop_front();
        cmp(x.tag, "Q",         32'(Q),         32'(x.q));
        cmp(x.tag, "tc",        32'(tc),        32'(x.tc));
        cmp(x.tag, "out",       32'(out),       32'(x.out));
        cmp(x.tag, "busy",      32'(busy),      32'(x.busy));
        cmp(x.tag, "done",      32'(done),      32'(x.done));
        cmp(x.tag, "cfg_err",   32'(cfg_err),   32'(x.err));
        cmp(x.tag, "cfg_ready", 32'(cfg_ready), 32'(x.rdy));
    endtask

    task automatic idle_chk(input string tag, input bit d, input bit e);
        push(tag, 0, 1'b0, exp_out, 1'b0, d, e, 1'b1);
        chk();
    endtask

    task automatic cfg(input int m, input int b);
        cfg_valid  = 1'b1;
        cfg_mod    = 4'(m);
        cfg_bursts = 8'(b);
    endtask

    task automatic cfg_off();
        cfg_valid  = 1'b0;
        cfg_mod    = '0;
        cfg_bursts = '0;
    endtask

    // Free-running RUN cycles at modulus m; optional stop on last cycle.
    task automatic run_free(input string tag, input int n, input int m,
                            input bit stop_last);
        for (int k = 0; k < n; k++) begin
            bit t;
            t = ((k % m) == m - 1);
            push(tag, k % m, t, exp_out, 1'b1, 1'b0, 1'b0, 1'b1);
            chk();
            if (stop_last && k == n - 1) stop = 1'b1;
            tick();
            stop = 1'b0;
            if (t) exp_out = ~exp_out;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cfg_off();
        tick();
        tick();
        reset = 1'b1;
        idle_chk("reset", 1'b0, 1'b0);

        // Default modulus 6, free run, stop on a non-tc cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_free("defaults", 25, 6, 1'b1);
        idle_chk("def_stop", 1'b0, 1'b0);

        // Config M=3 bursts=4 with start in the same cycle.
        cfg(3, 4);
        start = 1'b1;
        tick();
        cfg_off();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bit t;
            t = ((k % 3) == 2);
            push("burst", k % 3, t, exp_out, 1'b1, 1'b0, 1'b0, 1'b1);
            chk();
            tick();
            if (t) exp_out = ~exp_out;
        end
        idle_chk("burst_done", 1'b1, 1'b0);
        tick();
        idle_chk("burst_after", 1'b0, 1'b0);

        // M=6 run, shadow M=4 accepted at Q=2, stop on a tc cycle.
        cfg(6, 0);
        start = 1'b1;
        tick();
        cfg_off();
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            int q;
            bit t;
            bit r;
            if (k < 6) begin
                q = k;
                t = (k == 5);
                r = !(k >= 3);
            end else begin
                q = (k - 6) % 4;
                t = (q == 3);
                r = 1'b1;
            end
            push("shadow", q, t, exp_out, 1'b1, 1'b0, 1'b0, r);
            chk();
            if (k == 2) cfg(4, 0);
            if (k == 17) stop = 1'b1;
            tick();
            cfg_off();
            stop = 1'b0;
            if (t) exp_out = ~exp_out;
        end
        idle_chk("stop_tc", 1'b0, 1'b0);

        // start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        idle_chk("start_stop", 1'b0, 1'b0);

        // Illegal modulus leaves M=4 active.
        cfg(1, 5);
        idle_chk("bad_cfg_a", 1'b0, 1'b0);
        tick();
        cfg_off();
        start = 1'b1;
        idle_chk("err_pulse_a", 1'b0, 1'b1);
        tick();
        start = 1'b0;
        run_free("m_kept", 5, 4, 1'b1);
        idle_chk("m_kept_stop", 1'b0, 1'b0);

        // Illegal modulus then a legal config the very next cycle.
        cfg(0, 0);
        tick();
        cfg(5, 0);
        idle_chk("err_pulse_b", 1'b0, 1'b1);
        tick();
        cfg_off();
        idle_chk("err_clear", 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_free("m5", 5, 5, 1'b1);
        idle_chk("m5_stop", 1'b0, 1'b0);

        // Reset at Q=4 with shadow full; next run uses M=6.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push("rst_mid", k, k == 4, exp_out, 1'b1, 1'b0, 1'b0, k < 2);
            chk();
            if (k == 1) cfg(3, 0);
            if (k == 4) reset = 1'b0;
            tick();
            cfg_off();
            reset = 1'b1;
        end
        exp_out = 1'b0;
        idle_chk("rst_vals", 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_free("post_rst", 8, 6, 1'b1);
        idle_chk("post_rst_stop", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
